// File: rtl/voice_adsr_pkg.sv
// voice_adsr_pkg: shared synth-voice definitions.
//   env_state_t   : envelope FSM states (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE)
//   WAVE_*        : wave_sel codes
//   SILENCE_LEVEL : idle sample value, also assumed by the 4-channel mixer
//   LFSR_*        : noise generator taps and reset seed
package voice_adsr_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    localparam logic [1:0] WAVE_SAW      = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_NOISE    = 2'd3;

    localparam logic [7:0]  SILENCE_LEVEL = 8'd127;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator for one voice.
//   clk, rst        : clock, asynchronous active-low reset
//   sample_tick     : one-clk strobe; state only changes on these cycles
//   gate            : note on/off, level-sensitive
//   sustain_level   : sustain target
//   env             : current envelope level 0..255
//   busy            : registered, high while state != IDLE
//   restart         : combinational, gate rise seen in IDLE on this tick
//                     (oscillator phase restart)
module adsr_env
    import voice_adsr_pkg::*;
#(
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned DECAY_STEP   = 2,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned ENV_DIV      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       gate,
    input  logic [7:0] sustain_level,
    output logic [7:0] env,
    output logic       busy,
    output logic       restart
);

    localparam int unsigned DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);
    localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
    localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
    localparam logic [8:0] REL9 = 9'(RELEASE_STEP);

    env_state_t       state, state_n;
    logic [7:0]       env_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic             gate_q;
    logic             rise, step;
    logic [8:0]       env9, atk_sum, dec_diff, rel_diff;

    assign rise     = gate & ~gate_q;
    assign step     = (div_cnt == DIV_LAST);
    assign env9     = {1'b0, env};
    assign atk_sum  = env9 + ATK9;
    assign dec_diff = env9 - DEC9;
    assign rel_diff = env9 - REL9;
    assign restart  = sample_tick & rise & (state == ENV_IDLE);

    // Gate edges act on every tick; the step counter only paces level changes.
    always_comb begin
        state_n = state;
        env_n   = env;
        div_n   = (rise || step) ? '0 : div_cnt + DIV_W'(1);
        case (state)
            ENV_IDLE: begin
                env_n = '0;
                if (rise) state_n = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (!gate) begin
                    state_n = ENV_RELEASE;
                end else if (step) begin
                    if (atk_sum >= 9'd255) begin
                        env_n   = '1;
                        state_n = ENV_DECAY;
                    end else begin
                        env_n = atk_sum[7:0];
                    end
                end
            end
            ENV_DECAY: begin
                if (!gate) begin
                    state_n = ENV_RELEASE;
                end else if (step) begin
                    // Floor check before subtracting: env - step <= sustain.
                    if (env9 <= {1'b0, sustain_level} + DEC9) begin
                        env_n   = sustain_level;
                        state_n = ENV_SUSTAIN;
                    end else begin
                        env_n = dec_diff[7:0];
                    end
                end
            end
            ENV_SUSTAIN: begin
                if (!gate) state_n = ENV_RELEASE;
                else if (step) env_n = sustain_level;
            end
            ENV_RELEASE: begin
                if (rise) begin
                    state_n = ENV_ATTACK;
                end else if (step) begin
                    if (env9 <= REL9) begin
                        env_n   = '0;
                        state_n = ENV_IDLE;
                    end else begin
                        env_n = rel_diff[7:0];
                    end
                end
            end
            default: begin
                state_n = ENV_IDLE;
                env_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ENV_IDLE;
            env     <= '0;
            div_cnt <= '0;
            gate_q  <= 1'b0;
            busy    <= 1'b0;
        end else if (sample_tick) begin
            state   <= state_n;
            env     <= env_n;
            div_cnt <= div_n;
            gate_q  <= gate;
            busy    <= (state_n != ENV_IDLE);
        end
    end

endmodule

// File: rtl/voice_adsr.sv
// voice_adsr: single synth voice, phase-accumulator oscillator scaled by
// an ADSR envelope, one unsigned 8-bit sample per sample_tick.
//   clk, rst      : clock, asynchronous active-low reset
//   sample_tick   : one-clk strobe at sample rate
//   gate          : note on/off, level-sensitive
//   freq_step     : phase increment per sample_tick
//   wave_sel      : 0 saw, 1 square, 2 triangle, 3 noise (or square)
//   sustain_level : envelope sustain target
//   out           : unsigned sample, 127 = silence
//   busy          : high while the envelope is not IDLE
// Optional: define VOICE_NOISE_EN to add the 16-bit Galois LFSR noise
// source on wave_sel=3; without it wave_sel=3 gives the square wave.
module voice_adsr
    import voice_adsr_pkg::*;
#(
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned DECAY_STEP   = 2,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned ENV_DIV      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        gate,
    input  logic [15:0] freq_step,
    input  logic [1:0]  wave_sel,
    input  logic [7:0]  sustain_level,
    output logic [7:0]  out,
    output logic        busy
);

    logic [15:0]       phase;
    logic [7:0]        p, wave, env, sample_n;
    logic              restart;
    logic signed [8:0] s;
    logic signed [17:0] prod;
    logic [9:0]        scaled;
    logic [10:0]       level;

`ifdef VOICE_NOISE_EN
    logic [15:0] lfsr;
`endif

    adsr_env #(
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .RELEASE_STEP (RELEASE_STEP),
        .ENV_DIV      (ENV_DIV)
    ) u_env (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .gate          (gate),
        .sustain_level (sustain_level),
        .env           (env),
        .busy          (busy),
        .restart       (restart)
    );

    assign p = phase[15:8];

    always_comb begin
        wave = p;
        case (wave_sel)
            WAVE_SAW:      wave = p;
            WAVE_SQUARE:   wave = {8{p[7]}};
            WAVE_TRIANGLE: wave = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
`ifdef VOICE_NOISE_EN
            WAVE_NOISE:    wave = lfsr[7:0];
`else
            WAVE_NOISE:    wave = {8{p[7]}};
`endif
            default:       wave = p;
        endcase
    end

    // prod[17:8] is prod >>> 8; range -128..126 fits 10 bits, so the sum
    // with 127 only ever needs the low clamp, but both are kept.
    always_comb begin
        s        = $signed({1'b0, wave}) - 9'sd128;
        prod     = s * $signed({1'b0, env});
        scaled   = prod[17:8];
        level    = {scaled[9], scaled} + 11'd127;
        sample_n = level[10] ? '0 : (|level[9:8]) ? '1 : level[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            out   <= SILENCE_LEVEL;
`ifdef VOICE_NOISE_EN
            lfsr  <= LFSR_SEED;
`endif
        end else if (sample_tick) begin
            phase <= restart ? freq_step : phase + freq_step;
            out   <= sample_n;
`ifdef VOICE_NOISE_EN
            lfsr  <= lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_TAPS) : {1'b0, lfsr[15:1]};
`endif
        end
    end

endmodule

// File: tb/tb_voice_adsr.sv
module tb_voice_adsr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] freq_step = 16'h0000;
    logic [1:0]  wave_sel = 2'd0;
    logic [7:0]  sustain_level = 8'd100;
    logic [7:0]  out, out4;
    logic        busy, busy4;

    int total = 0;
    int bad   = 0;

    // Bench-side model state: expected p and env before the next tick.
    int          ph = 0;
    int          ev = 0;
    int          fs = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    int          mn, mx;

    int tbl4 [18] = '{127, 127, 127, 127, 123, 123, 123, 123, 119,
                      119, 119, 119, 119, 119, 119, 119, 119, 115};

    always #5 clk = ~clk;

    voice_adsr #(
        .ATTACK_STEP (8),
        .DECAY_STEP  (2),
        .RELEASE_STEP(1),
        .ENV_DIV     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .freq_step    (freq_step),
        .wave_sel     (wave_sel),
        .sustain_level(sustain_level),
        .out          (out),
        .busy         (busy)
    );

    voice_adsr #(
        .ATTACK_STEP (8),
        .DECAY_STEP  (2),
        .RELEASE_STEP(1),
        .ENV_DIV     (4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .freq_step    (freq_step),
        .wave_sel     (wave_sel),
        .sustain_level(sustain_level),
        .out          (out4),
        .busy         (busy4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wv(input int pp, input int sel, input logic [15:0] l);
        int w;
        case (sel)
            0: w = pp;
            1: w = (pp >= 128) ? 255 : 0;
            2: w = (pp >= 128) ? 255 - 2 * (pp % 128) : 2 * (pp % 128);
`ifdef VOICE_NOISE_EN
            default: w = int'(l[7:0]);
`else
            default: w = (pp >= 128) ? 255 : 0;
`endif
        endcase
        return w;
    endfunction

    function automatic int exp_out(input int w, input int e);
        int pr, v;
        pr = (w - 128) * e;
        v  = 127 + (pr >>> 8);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Called at a falling edge; one sample_tick spans the next rising edge.
    task automatic pulse();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lfsr_m = lfsr_m[0] ? ({1'b0, lfsr_m[15:1]} ^ 16'hB400) : {1'b0, lfsr_m[15:1]};
    endtask

    task automatic tick_exp(input string tag, input int next_env, input bit restart);
        int e;
        e = exp_out(wv(ph, int'(wave_sel), lfsr_m), ev);
        pulse();
        chk(tag, int'(out), e);
        ev = next_env;
        ph = restart ? fs : (ph + fs) % 256;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ph = 0;
        ev = 0;
        lfsr_m = 16'hACE1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", int'(out), 127);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;

        // Idle: nothing moves without a gate rise
        repeat (3) tick_exp("idle", 0, 0);
        chk("idle_busy", int'(busy), 0);

        // Attack 0 -> 255 in 32 steps, decay by 2 to 100 in 78 steps
        gate = 1'b1;
        tick_exp("rise", 0, 1);
        chk("rise_busy", int'(busy), 1);
        for (int n = 1; n <= 32; n++) tick_exp("atk", (n == 32) ? 255 : 8 * n, 0);
        for (int k = 1; k <= 78; k++) tick_exp("dec", (k == 78) ? 100 : 255 - 2 * k, 0);
        sustain_level = 8'd60;
        tick_exp("sus_a", 60, 0);
        tick_exp("sus_b", 60, 0);

        // Release from sustain
        gate = 1'b0;
        tick_exp("rel0", 60, 0);
        chk("rel0_busy", int'(busy), 1);
        for (int j = 1; j <= 60; j++) begin
            tick_exp("rel", 60 - j, 0);
            chk("rel_busy", int'(busy), (j < 60) ? 1 : 0);
        end
        repeat (2) tick_exp("idle_after_rel", 0, 0);

        // Gate drop during attack at env=64
        gate = 1'b1;
        tick_exp("d_rise", 0, 1);
        for (int n = 1; n <= 8; n++) tick_exp("d_atk", 8 * n, 0);
        gate = 1'b0;
        tick_exp("d_drop", 64, 0);
        chk("d_drop_busy", int'(busy), 1);
        for (int j = 1; j <= 64; j++) begin
            tick_exp("d_rel", 64 - j, 0);
            chk("d_rel_busy", int'(busy), (j < 64) ? 1 : 0);
        end
        repeat (2) tick_exp("d_idle", 0, 0);

        // Saw walk at env=255, then re-rise during release at env=30
        freq_step = 16'h0100;
        fs = 1;
        sustain_level = 8'd255;
        gate = 1'b1;
        tick_exp("e_rise", 0, 1);
        for (int n = 1; n <= 32; n++) tick_exp("e_atk", (n == 32) ? 255 : 8 * n, 0);
        tick_exp("e_dec", 255, 0);
        mn = 255;
        mx = 0;
        for (int i = 0; i < 300; i++) begin
            tick_exp("saw", 255, 0);
            if (int'(out) < mn) mn = int'(out);
            if (int'(out) > mx) mx = int'(out);
        end
        chk("saw_min", mn, 0);
        chk("saw_max", mx, 253);
        gate = 1'b0;
        tick_exp("e_drop", 255, 0);
        for (int j = 1; j <= 225; j++) tick_exp("e_rel", 255 - j, 0);
        gate = 1'b1;
        tick_exp("rerise", 30, 0);
        chk("rerise_busy", int'(busy), 1);
        tick_exp("att38", 38, 0);
        tick_exp("att46", 46, 0);

        // Asynchronous reset mid-note, checked before any clock edge
        #2;
        rst = 1'b0;
        gate = 1'b0;
        #1;
        chk("arst_out", int'(out), 127);
        chk("arst_busy", int'(busy), 0);
        chk("arst_busy4", int'(busy4), 0);
        ph = 0;
        ev = 0;
        lfsr_m = 16'hACE1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick_exp("post_rst", 0, 0);
        chk("post_rst_busy", int'(busy), 0);

        // Square, triangle, wave_sel=3 at env=255
        wave_sel = 2'd1;
        gate = 1'b1;
        tick_exp("g_rise", 0, 1);
        for (int n = 1; n <= 32; n++) tick_exp("g_atk", (n == 32) ? 255 : 8 * n, 0);
        tick_exp("g_dec", 255, 0);
        repeat (40) tick_exp("square", 255, 0);
        wave_sel = 2'd2;
        freq_step = 16'h0700;
        fs = 7;
        repeat (80) tick_exp("triangle", 255, 0);
        wave_sel = 2'd3;
        repeat (40) tick_exp("sel3", 255, 0);

        // Envelope pacing with ENV_DIV=4, gate edges mid-count
        do_reset();
        gate = 1'b0;
        wave_sel = 2'd0;
        freq_step = 16'h0000;
        fs = 0;
        sustain_level = 8'd100;
        gate = 1'b1;
        pulse();
        chk("div4_busy", int'(busy4), 1);
        for (int t = 1; t <= 18; t++) begin
            if (t == 10) gate = 1'b0;
            if (t == 13) gate = 1'b1;
            pulse();
            chk("div4_out", int'(out4), tbl4[t-1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
